// File: rtl/oh_barrier3.sv
// ============================================================================
// oh_barrier3 : three-lane arrival barrier with registered go/go_ready output
// Optional timeout counter enabled by macro OH_BARRIER_TIMEOUT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module oh_barrier3 #(
    parameter int CW = 8,
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          clear,
    input  logic          a0,
    input  logic          a1,
    input  logic          b0,
    input  logic          b1,
    input  logic          c0,
    input  logic          c1,
    output logic          go,
    input  logic          go_ready,
    output logic [2:0]    pending,
    output logic [2:0]    early,
    output logic          ovf,
    output logic [CW-1:0] count,
    input  logic [TW-1:0] timeout_limit,
    output logic          timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FIRE    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  arrive;
    logic [2:0]  pending_nxt;
    logic [2:0]  early_nxt;
    logic        ovf_nxt;
    logic        handshake;

    // Both sources of a lane pulsing together collapse into one arrival.
    assign arrive    = {c0 | c1, b0 | b1, a0 | a1};
    assign handshake = go & go_ready;

    always_comb begin
        pending_nxt = pending;
        early_nxt   = early;
        ovf_nxt     = ovf;
        state_nxt   = state;

        if (clear) begin
            pending_nxt = 3'b000;
            early_nxt   = 3'b000;
            ovf_nxt     = 1'b0;
        end else if (state == FIRE) begin
            if (handshake) begin
                pending_nxt = early | arrive;
                early_nxt   = early & arrive;
            end else begin
                early_nxt = early | arrive;
                if ((early & arrive) != 3'b000) begin
                    ovf_nxt = 1'b1;
                end
            end
        end else begin
            pending_nxt = pending | arrive;
            early_nxt   = early | (pending & arrive);
            if ((pending & early & arrive) != 3'b000) begin
                ovf_nxt = 1'b1;
            end
        end

        // The state is always a pure function of the pending set it lands on.
        if (clear || pending_nxt == 3'b000) begin
            state_nxt = IDLE;
        end else if (pending_nxt == 3'b111) begin
            state_nxt = FIRE;
        end else begin
            state_nxt = COLLECT;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= IDLE;
            go      <= 1'b0;
            pending <= 3'b000;
            early   <= 3'b000;
            ovf     <= 1'b0;
        end else begin
            state   <= state_nxt;
            go      <= (state_nxt == FIRE);
            pending <= pending_nxt;
            early   <= early_nxt;
            ovf     <= ovf_nxt;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count <= '0;
        end else if (!clear && handshake) begin
            count <= count + 1'b1;
        end
    end

`ifdef OH_BARRIER_TIMEOUT_EN
    logic [TW-1:0] tcnt;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tcnt    <= '0;
            timeout <= 1'b0;
        end else if (clear) begin
            tcnt    <= '0;
            timeout <= 1'b0;
        end else begin
            if (state_nxt != COLLECT) begin
                tcnt <= '0;
            end else if (state == COLLECT && tcnt != '1) begin
                tcnt <= tcnt + 1'b1;
            end
            if (timeout_limit != '0 && tcnt == timeout_limit) begin
                timeout <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_limit;

    assign unused_timeout_limit = ^timeout_limit;
    assign timeout              = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_oh_barrier3.sv
// ============================================================================
// tb_oh_barrier3 : directed bench for oh_barrier3 (CW=8 and CW=2 instances)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_oh_barrier3;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        clear = 1'b0;
    logic        a0 = 1'b0, a1 = 1'b0, b0 = 1'b0, b1 = 1'b0, c0 = 1'b0, c1 = 1'b0;
    logic        go_ready = 1'b1;
    logic [15:0] timeout_limit = 16'd0;

    logic        go, ovf, timeout;
    logic [2:0]  pending, early;
    logic [7:0]  count;

    logic        go2;
    logic [1:0]  count2;
    logic [2:0]  unused_pending2, unused_early2;
    logic        unused_ovf2, unused_timeout2;

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;

`ifdef OH_BARRIER_TIMEOUT_EN
    localparam int TO_EXP = 1;
`else
    localparam int TO_EXP = 0;
`endif

    always #5 clk = ~clk;

    oh_barrier3 #(.CW(8), .TW(16)) dut (
        .clk(clk), .nreset(nreset), .clear(clear),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .c0(c0), .c1(c1),
        .go(go), .go_ready(go_ready), .pending(pending), .early(early),
        .ovf(ovf), .count(count), .timeout_limit(timeout_limit), .timeout(timeout)
    );

    oh_barrier3 #(.CW(2), .TW(16)) dut2 (
        .clk(clk), .nreset(nreset), .clear(clear),
        .a0(a0), .a1(a1), .b0(b0), .b1(b1), .c0(c0), .c1(c1),
        .go(go2), .go_ready(go_ready), .pending(unused_pending2), .early(unused_early2),
        .ovf(unused_ovf2), .count(count2), .timeout_limit(timeout_limit),
        .timeout(unused_timeout2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // src = {c1,c0,b1,b0,a1,a0}, held for exactly one clock edge
    task automatic pulse(input logic [5:0] src);
        {c1, c0, b1, b0, a1, a0} = src;
        step();
        {c1, c0, b1, b0, a1, a0} = 6'b0;
    endtask

    task automatic chk_count();
        chk("count", 32'(count), 32'(exp_cnt % 256));
        chk("count2", 32'(count2), 32'(exp_cnt % 4));
    endtask

    initial begin
        // reset state
        step();
        step();
        chk("rst_go", 32'(go), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_early", 32'(early), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_timeout", 32'(timeout), 0);
        chk_count();
        #2 nreset = 1'b1;

        // staggered arrivals, go_ready high
        go_ready = 1'b1;
        pulse(6'b000001);
        chk("t1_pend_a", 32'(pending), 32'h1);
        chk("t1_go_a", 32'(go), 0);
        step();
        pulse(6'b000100);
        chk("t1_pend_ab", 32'(pending), 32'h3);
        step();
        pulse(6'b010000);
        chk("t1_pend_abc", 32'(pending), 32'h7);
        chk("t1_go", 32'(go), 1);
        step();
        exp_cnt++;
        chk("t1_go_drop", 32'(go), 0);
        chk("t1_pend_after", 32'(pending), 0);
        chk_count();

        // simultaneous arrivals, consumer stalls 4 cycles
        go_ready = 1'b0;
        pulse(6'b101010);
        chk("t2_go_c1", 32'(go), 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_go_hold", 32'(go), 1);
            chk("t2_pend_hold", 32'(pending), 32'h7);
        end
        chk_count();
        go_ready = 1'b1;
        step();
        exp_cnt++;
        chk("t2_go_drop", 32'(go), 0);
        chk("t2_pend_idle", 32'(pending), 0);
        chk_count();

        // early arrivals during FIRE and overflow
        go_ready = 1'b0;
        pulse(6'b010101);
        chk("t3_go", 32'(go), 1);
        pulse(6'b000001);
        chk("t3_early_a", 32'(early), 32'h1);
        chk("t3_ovf0", 32'(ovf), 0);
        pulse(6'b000100);
        chk("t3_early_ab", 32'(early), 32'h3);
        chk("t3_ovf0b", 32'(ovf), 0);
        pulse(6'b000001);
        chk("t3_ovf1", 32'(ovf), 1);
        chk("t3_early_keep", 32'(early), 32'h3);
        go_ready = 1'b1;
        step();
        exp_cnt++;
        chk("t3_hs_go", 32'(go), 0);
        chk("t3_hs_pend", 32'(pending), 32'h3);
        chk("t3_hs_early", 32'(early), 0);
        chk_count();
        pulse(6'b010000);
        chk("t3_refire", 32'(go), 1);
        step();
        exp_cnt++;
        chk("t3_idle", 32'(pending), 0);
        chk("t3_ovf_sticky", 32'(ovf), 1);
        chk_count();

        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_ovf", 32'(ovf), 0);
        chk_count();

        // back-to-back rounds
        go_ready = 1'b0;
        pulse(6'b010101);
        pulse(6'b101010);
        chk("t4_early", 32'(early), 32'h7);
        chk("t4_ovf", 32'(ovf), 0);
        go_ready = 1'b1;
        step();
        exp_cnt++;
        chk("t4_go_stay", 32'(go), 1);
        chk("t4_pend", 32'(pending), 32'h7);
        chk("t4_early0", 32'(early), 0);
        chk_count();
        step();
        exp_cnt++;
        chk("t4_go_drop", 32'(go), 0);
        chk_count();

        // five rounds; CW=2 instance wraps
        for (int r = 0; r < 5; r++) begin
            pulse(6'b011001);
            chk("t5_go2", 32'(go2), 1);
            step();
            exp_cnt++;
            chk("t5_go2_drop", 32'(go2), 0);
            chk_count();
        end

        // clear beats a simultaneous handshake; arrivals in clear cycle discarded
        go_ready = 1'b0;
        pulse(6'b010101);
        pulse(6'b000001);
        chk("t6_early", 32'(early), 32'h1);
        go_ready = 1'b1;
        clear = 1'b1;
        pulse(6'b000001);
        clear = 1'b0;
        chk("t6_go", 32'(go), 0);
        chk("t6_pend", 32'(pending), 0);
        chk("t6_early0", 32'(early), 0);
        chk("t6_ovf", 32'(ovf), 0);
        chk_count();

        // timeout
        timeout_limit = 16'd10;
        pulse(6'b000001);
        for (int i = 0; i < 10; i++) step();
        chk("t7_to_pre", 32'(timeout), 0);
        step();
        chk("t7_to_hit", 32'(timeout), 32'(TO_EXP));
        pulse(6'b000100);
        pulse(6'b010000);
        chk("t7_go", 32'(go), 1);
        chk("t7_to_fire", 32'(timeout), 32'(TO_EXP));
        step();
        exp_cnt++;
        chk("t7_to_after", 32'(timeout), 32'(TO_EXP));
        chk_count();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t7_to_clr", 32'(timeout), 0);

        // asynchronous reset in FIRE
        go_ready = 1'b0;
        pulse(6'b010101);
        chk("t8_go", 32'(go), 1);
        #2 nreset = 1'b0;
        #1;
        exp_cnt = 0;
        chk("t8_go_async", 32'(go), 0);
        chk("t8_pend", 32'(pending), 0);
        chk_count();
        step();
        #2 nreset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
